// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - synchronise/debounce switch banks and step key, generate step pulses
// Two switch banks and one active-low key feed the pipelined computer's io inputs and single-step control.

module io_input_debounce #(
  parameter int                WIDTH     = 6,
  parameter int                DB_CYCLES = 4,
  parameter logic [WIDTH-1:0]  RST_VAL   = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             update
);

  localparam int            CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt;

  // The counter counts any run of samples that differ from the stable value, so the bank moves atomically.
  assign update = (sync2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1  <= RST_VAL;
      sync2  <= RST_VAL;
      stable <= RST_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (update) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (sync2 == stable) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module io_input_conditioner #(
  parameter int W            = 6,
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] sw0_raw,
  input  logic [W-1:0] sw1_raw,
  input  logic         key_raw,
  output logic [W-1:0] io_input_0,
  output logic [W-1:0] io_input_1,
  output logic         in_changed,
  output logic         step_pulse
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DELAY_LAST = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic          sw0_update;
  logic          sw1_update;
  logic          key_stable;
  logic          key_update;
  logic          pressed_nxt;
  logic [1:0]    state;
  logic [TW-1:0] timer;

  io_input_debounce #(.WIDTH(W), .DB_CYCLES(DB_CYCLES), .RST_VAL('0)) u_db_sw0 (
    .clock  (clock),
    .resetn (resetn),
    .raw    (sw0_raw),
    .stable (io_input_0),
    .update (sw0_update)
  );

  io_input_debounce #(.WIDTH(W), .DB_CYCLES(DB_CYCLES), .RST_VAL('0)) u_db_sw1 (
    .clock  (clock),
    .resetn (resetn),
    .raw    (sw1_raw),
    .stable (io_input_1),
    .update (sw1_update)
  );

  io_input_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_key (
    .clock  (clock),
    .resetn (resetn),
    .raw    (key_raw),
    .stable (key_stable),
    .update (key_update)
  );

  // A 1-bit update always flips the key; the FSM acts on the value being accepted this edge,
  // so the first pulse coincides with acceptance and release suppresses a pulse on its own edge.
  assign pressed_nxt = ~(key_stable ^ key_update);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_changed <= 1'b0;
    end else begin
      in_changed <= sw0_update | sw1_update;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      timer      <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pressed_nxt) begin
            step_pulse <= 1'b1;
            timer      <= '0;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!pressed_nxt) begin
            state <= ST_IDLE;
          end else if (REPEAT_DELAY != 0 && timer == DELAY_LAST) begin
            step_pulse <= 1'b1;
            timer      <= '0;
            state      <= ST_REPEAT;
          end else if (REPEAT_DELAY != 0) begin
            timer <= timer + TW'(1);
          end
        end
        ST_REPEAT: begin
          if (!pressed_nxt) begin
            state <= ST_IDLE;
          end else if (timer == RATE_LAST) begin
            step_pulse <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
